// File: rtl/freq_counter_multi_pkg.sv
// Shared state encoding, default parameters and result-slice helper for the
// multi-channel gated frequency counter.
package freq_counter_multi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } fc_state_e;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_COUNT_WIDTH = 32;
  localparam int DEFAULT_GATE_WIDTH  = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic int result_offset(input int channel, input int width);
    return channel * width;
  endfunction

endpackage

// File: rtl/freq_counter_channel.sv
// One measurement lane: input synchroniser, rising-edge detector and a
// saturating edge counter with a sticky saturation flag.
module freq_counter_channel #(
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   measure,
  input  logic                   clear,
  input  logic                   count_en,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   saturated
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // The synchroniser keeps running in every state so edge detection is
  // already settled when a window opens.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], measure};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // An edge arriving while the counter is full is lost and flagged instead.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count     <= '0;
      saturated <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      saturated <= 1'b0;
    end else if (count_en && rise) begin
      if (&count) begin
        saturated <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_counter_multi.sv
// Multi-channel gated frequency counter: FSM, gate counter and result latches.
// Optional FREQ_COUNTER_MULTI_IRQ_EN adds a sticky completion interrupt.
module freq_counter_multi
  import freq_counter_multi_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int GATE_WIDTH  = DEFAULT_GATE_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                            io_clock,
  input  logic                            io_sysReset_n,
  input  logic [CHANNELS-1:0]             io_measure,
  input  logic [CHANNELS-1:0]             io_channelEnable,
  input  logic [GATE_WIDTH-1:0]           io_gatePeriod,
  input  logic                            io_continuous,
  input  logic                            io_start,
  input  logic                            io_stop,
  output logic                            io_busy,
  output logic                            io_done,
  output logic [CHANNELS*COUNT_WIDTH-1:0] io_result,
  output logic [CHANNELS-1:0]             io_overflow
`ifdef FREQ_COUNTER_MULTI_IRQ_EN
  ,
  output logic                            io_irq,
  input  logic                            io_irqClear
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARM   = ARM;
  localparam logic [1:0] ST_GATE  = GATE;
  localparam logic [1:0] ST_LATCH = LATCH;

  logic [1:0]                      state;
  logic [GATE_WIDTH-1:0]           gate_cnt;
  logic [GATE_WIDTH-1:0]           period_q;
  logic                            continuous_q;
  logic [CHANNELS-1:0]             enable_q;
  logic [CHANNELS*COUNT_WIDTH-1:0] result_q;
  logic [CHANNELS-1:0]             overflow_q;
  logic                            done_q;
  logic [COUNT_WIDTH-1:0]          ch_count [CHANNELS];
  logic [CHANNELS-1:0]             ch_sat;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    freq_counter_channel #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_channel (
      .clock    (io_clock),
      .reset_n  (io_sysReset_n),
      .measure  (io_measure[i]),
      .clear    (state == ST_ARM),
      .count_en ((state == ST_GATE) && enable_q[i]),
      .count    (ch_count[i]),
      .saturated(ch_sat[i])
    );
  end

  // Stop wins over everything and leaves published results untouched.
  always_ff @(posedge io_clock) begin
    if (!io_sysReset_n) begin
      state        <= ST_IDLE;
      gate_cnt     <= '0;
      period_q     <= '0;
      continuous_q <= 1'b0;
      enable_q     <= '0;
      result_q     <= '0;
      overflow_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (io_stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (io_start && (io_gatePeriod != '0)) begin
              period_q     <= io_gatePeriod;
              continuous_q <= io_continuous;
              state        <= ST_ARM;
            end
          end
          ST_ARM: begin
            enable_q <= io_channelEnable;
            gate_cnt <= period_q;
            state    <= ST_GATE;
          end
          ST_GATE: begin
            gate_cnt <= gate_cnt - 1'b1;
            if (gate_cnt == GATE_WIDTH'(1)) begin
              state <= ST_LATCH;
            end
          end
          ST_LATCH: begin
            for (int i = 0; i < CHANNELS; i++) begin
              result_q[result_offset(i, COUNT_WIDTH) +: COUNT_WIDTH] <=
                enable_q[i] ? ch_count[i] : '0;
              overflow_q[i] <= enable_q[i] & ch_sat[i];
            end
            done_q <= 1'b1;
            state  <= continuous_q ? ST_ARM : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign io_busy     = (state != ST_IDLE);
  assign io_done     = done_q;
  assign io_result   = result_q;
  assign io_overflow = overflow_q;

`ifdef FREQ_COUNTER_MULTI_IRQ_EN
  logic irq_q;

  // Setting from the visible done pulse lets a coincident clear lose.
  always_ff @(posedge io_clock) begin
    if (!io_sysReset_n) begin
      irq_q <= 1'b0;
    end else if (done_q) begin
      irq_q <= 1'b1;
    end else if (io_irqClear) begin
      irq_q <= 1'b0;
    end
  end

  assign io_irq = irq_q;
`endif

endmodule
